// File: rtl/tdc_frame_buf.sv
// Multi-channel TDC frame buffer: per-channel calibrated capture into a
// ping-pong bank pair, with word-by-word readout toward the SPI slave.
module tdc_frame_buf #(
  parameter  int NCH   = 4,
  parameter  int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  parameter  int DEPTH = 7,
  parameter  int DW    = 19,
  parameter  int CW    = 20,
  localparam int CNTW  = $clog2(DEPTH + 1),
  localparam int OW    = DW + CNTW + CHW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tdc_valid,
  input  logic [CHW-1:0]    tdc_ch,
  input  logic [DW-1:0]     tdc_data,
  input  logic [NCH*CW-1:0] tdc_calib,
  output logic              tdc_ready,
  input  logic              rd_req,
  input  logic              rd_en,
  output logic [OW-1:0]     out_word,
  output logic              int_o,
  output logic              read_done,
  output logic              ovf,
  output logic              lost
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = ((DW + 1 > CW) ? DW + 1 : CW) + 1;

  typedef enum logic [1:0] {IDLE, CAPT, DRAIN, HOLD} state_t;
  typedef struct packed {
    logic [DW-1:0]  data;
    logic [CHW-1:0] ch;
  } entry_t;

  state_t            st_q, st_d;
  entry_t            mem_q [2][DEPTH];
  logic              sel_q, sel_d;          // write bank; read bank is ~sel_q
  logic              p_vld_q;
  logic [DW-1:0]     p_raw_q;
  logic [CHW-1:0]    p_ch_q;
  logic [AW-1:0]     p_slot_q, slot_d;
  logic [CNTW-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d, rd_ptr_q, rd_ptr_d;
  logic              wovf_q, wovf_d, ovf_q, ovf_d, rfull_q, rfull_d;
  logic              lost_q, read_done_q;
  logic              ch_ok, acc, drop, store, swap, adv, last;
  logic signed [CW-1:0] cal_a [2**CHW];
  logic signed [SW-1:0] sum;
  logic [DW-1:0]     sat;
  entry_t            rd_e;

  for (genvar i = 0; i < 2**CHW; i++) begin : g_cal
    if (i < NCH) begin : g_on
      assign cal_a[i] = tdc_calib[i*CW +: CW];
    end else begin : g_off
      assign cal_a[i] = '0;
    end
  end

  assign ch_ok     = int'(tdc_ch) < NCH;
  assign tdc_ready = (st_q == IDLE) || (st_q == CAPT);
  assign acc       = tdc_valid & tdc_ready & ch_ok;
  assign drop      = tdc_valid & ~(tdc_ready & ch_ok);
  assign adv       = rd_req & rd_en & rfull_q;
  assign last      = adv & (rd_ptr_q == rcnt_q - CNTW'(1));

  // Widen both operands so the signed sum can neither wrap nor lose the sign.
  assign sum = $signed({{(SW-DW){1'b0}}, p_raw_q}) +
               $signed({{(SW-CW){cal_a[p_ch_q][CW-1]}}, cal_a[p_ch_q]});
  always_comb begin
    sat = sum[DW-1:0];
    if (sum[SW-1])            sat = '0;
    else if (|sum[SW-2:DW])   sat = '1;
  end

  always_comb begin
    st_d   = st_q;
    store  = 1'b0;
    slot_d = '0;
    wcnt_d = wcnt_q;
    wovf_d = wovf_q;
    swap   = 1'b0;
    unique case (st_q)
      IDLE: if (acc) begin
        store  = 1'b1;
        wcnt_d = CNTW'(1);
        wovf_d = 1'b0;
        st_d   = CAPT;
      end
      CAPT: begin
        if (acc) begin
          if (int'(wcnt_q) < DEPTH) begin
            store  = 1'b1;
            slot_d = wcnt_q[AW-1:0];
            wcnt_d = wcnt_q + CNTW'(1);
          end else begin
            wovf_d = 1'b1;
          end
        end
        if (!tdc_valid) st_d = DRAIN;
      end
      // A release on this edge frees the read bank before the commit looks at it.
      DRAIN: begin
        if (!rfull_q || last) begin
          swap = 1'b1;
          st_d = IDLE;
        end else begin
          st_d = HOLD;
        end
      end
      HOLD: if (last) begin
        swap = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d    = sel_q;
    rfull_d  = rfull_q;
    rd_ptr_d = rd_ptr_q;
    rcnt_d   = rcnt_q;
    ovf_d    = ovf_q;
    if (adv) rd_ptr_d = rd_ptr_q + CNTW'(1);
    if (last) begin
      rfull_d  = 1'b0;
      rd_ptr_d = '0;
    end
    if (swap) begin
      sel_d    = ~sel_q;
      rfull_d  = 1'b1;
      rd_ptr_d = '0;
      rcnt_d   = wcnt_q;
      ovf_d    = wovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      sel_q       <= 1'b0;
      p_vld_q     <= 1'b0;
      p_raw_q     <= '0;
      p_ch_q      <= '0;
      p_slot_q    <= '0;
      wcnt_q      <= '0;
      wovf_q      <= 1'b0;
      rcnt_q      <= '0;
      rd_ptr_q    <= '0;
      rfull_q     <= 1'b0;
      ovf_q       <= 1'b0;
      lost_q      <= 1'b0;
      read_done_q <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < DEPTH; s++) mem_q[b][s] <= '0;
    end else begin
      st_q        <= st_d;
      sel_q       <= sel_d;
      p_vld_q     <= store;
      p_raw_q     <= tdc_data;
      p_ch_q      <= tdc_ch;
      p_slot_q    <= slot_d;
      wcnt_q      <= wcnt_d;
      wovf_q      <= wovf_d;
      rcnt_q      <= rcnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rfull_q     <= rfull_d;
      ovf_q       <= ovf_d;
      lost_q      <= (lost_q & ~last) | drop;
      read_done_q <= last;
      if (p_vld_q) mem_q[sel_q][p_slot_q] <= '{data: sat, ch: p_ch_q};
    end
  end

  assign rd_e      = mem_q[~sel_q][rd_ptr_q[AW-1:0]];
  assign out_word  = rfull_q ? {rd_e.data, rcnt_q, rd_e.ch} : '0;
  assign int_o     = rfull_q;
  assign ovf       = ovf_q;
  assign lost      = lost_q;
  assign read_done = read_done_q;
endmodule
